regfile_port_arbiter: RTL
=========================

REGFILE_PORT_ARBITER -- requirements
Module: regfile_port_arbiter

Interface
REQ-001 SHALL have parameter REGFILE_ADDRESS_WIDTH, default 3, register address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, register data width.
REQ-003 SHALL have port clock  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  2  per-requester access request; bit i belongs to requester i (CPU0/CPU1).
REQ-006 SHALL have port we  input  2  per-requester command type: 1 = write, 0 = read.
REQ-007 SHALL have port r1addr  input  2*REGFILE_ADDRESS_WIDTH  read address A; slice i belongs to requester i.
REQ-008 SHALL have port r2addr  input  2*REGFILE_ADDRESS_WIDTH  read address B, per requester.
REQ-009 SHALL have port waddr  input  2*REGFILE_ADDRESS_WIDTH  write address, per requester.
REQ-010 SHALL have port wdata  input  2*DATA_WIDTH  write data, per requester.
REQ-011 SHALL have port gnt  output  2  one-cycle acceptance pulse per requester.
REQ-012 SHALL have port rvalid  output  2  one-cycle read-data-valid pulse per requester.
REQ-013 SHALL have port r1data  output  DATA_WIDTH  read result A, shared, qualified by rvalid.
REQ-014 SHALL have port r2data  output  DATA_WIDTH  read result B, shared, qualified by rvalid.
REQ-015 SHALL have ports rf_r1addr, rf_r2addr, rf_waddr  output  REGFILE_ADDRESS_WIDTH each  register-file addresses.
REQ-016 SHALL have port rf_wdata  output  DATA_WIDTH, and rf_reg_write  output  1, register-file write port.
REQ-017 SHALL have ports rf_r1data, rf_r2data  input  DATA_WIDTH each  combinational register-file read data.

Function
REQ-018 Arbitration SHALL occur at each rising edge over eligible requests; requester i is eligible iff req[i]=1 and gnt[i]=0 in the current cycle (no same-requester grant in consecutive cycles).
REQ-019 One eligible requester SHALL win outright; with both eligible, the requester not granted most recently SHALL win (round-robin pointer, updated only on a grant).
REQ-020 On a win by requester i at edge k, gnt[i] SHALL be 1 for exactly the cycle after edge k (issue cycle); gnt SHALL be one-hot or zero.
REQ-021 In the issue cycle, rf_* outputs SHALL be registered copies of requester i's slices sampled at edge k; rf_reg_write SHALL equal we[i] as sampled.
REQ-022 In cycles with no grant, rf_reg_write SHALL be 0 and rf_r1addr/rf_r2addr/rf_waddr/rf_wdata SHALL be 0.
REQ-023 For a granted read, r1data/r2data SHALL capture rf_r1data/rf_r2data at the edge ending the issue cycle and rvalid[i] SHALL pulse for that following cycle (request-sample-to-data latency 2 cycles).
REQ-024 For a granted write, rvalid SHALL stay 0; the write completes inside the issue cycle (register file writes on falling edge), so any read issued in a later cycle returns the new value.
REQ-025 r1data/r2data SHALL hold their last captured value when rvalid=0.
REQ-026 Requesters SHALL hold req and payload stable until gnt is seen; arbiter samples payload only at the winning edge.
REQ-027 Throughput: alternating requests from both requesters SHALL be granted every cycle; a single requester SHALL be granted at most every other cycle.
REQ-028 Address 0 commands SHALL be issued unmodified (register file forces reads of address 0 to 0).

Reset
REQ-029 While reset_n=0, gnt, rvalid, r1data, r2data, rf_reg_write and all rf_* address/data outputs SHALL be 0, asynchronously.
REQ-030 Reset SHALL set the round-robin pointer so requester 0 wins the first tie; a reset during an issue or response cycle SHALL discard that command (no rvalid after reset release).

Verification
REQ-031 Single read: req=01, we=0, r1addr0=3, r2addr0=5 with regs 3=0xAA, 5=0xBB -> gnt=01 next cycle with rf_r1addr=3, rf_r2addr=5; following cycle rvalid=01, r1data=0xAA, r2data=0xBB.
REQ-032 Tie after reset: req=11 held -> gnt sequence 01,10,01,10 on consecutive cycles.
REQ-033 Single requester held: req=10 held 6 cycles -> gnt=10,00,10,00,10,00.
REQ-034 Write then read: CPU1 writes waddr=2, wdata=0x1234, then CPU0 reads r1addr=2 -> rf_reg_write=1 for one cycle; CPU0 rvalid with r1data=0x1234.
REQ-035 Reset mid-op: reset_n low during issue cycle of a read -> all outputs 0 immediately; after release, no rvalid; next tie grants requester 0.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
// Two-requester round-robin arbiter in front of a 2R/1W register file; grant 1 cycle after request, read data 1 cycle after grant.
// No same-requester grants back to back; losers hold req and payload until gnt (no other backpressure).
module regfile_port_arbiter #(
    parameter int REGFILE_ADDRESS_WIDTH = 3,
    parameter int DATA_WIDTH            = 64
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic [1:0]                         req,
    input  logic [1:0]                         we,
    input  logic [2*REGFILE_ADDRESS_WIDTH-1:0] r1addr,
    input  logic [2*REGFILE_ADDRESS_WIDTH-1:0] r2addr,
    input  logic [2*REGFILE_ADDRESS_WIDTH-1:0] waddr,
    input  logic [2*DATA_WIDTH-1:0]            wdata,
    output logic [1:0]                         gnt,
    output logic [1:0]                         rvalid,
    output logic [DATA_WIDTH-1:0]              r1data,
    output logic [DATA_WIDTH-1:0]              r2data,
    output logic [REGFILE_ADDRESS_WIDTH-1:0]   rf_r1addr,
    output logic [REGFILE_ADDRESS_WIDTH-1:0]   rf_r2addr,
    output logic [REGFILE_ADDRESS_WIDTH-1:0]   rf_waddr,
    output logic [DATA_WIDTH-1:0]              rf_wdata,
    output logic                               rf_reg_write,
    input  logic [DATA_WIDTH-1:0]              rf_r1data,
    input  logic [DATA_WIDTH-1:0]              rf_r2data
);
    localparam int AW = REGFILE_ADDRESS_WIDTH;
    localparam int DW = DATA_WIDTH;

    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvalid_q, rvalid_d;
    logic [DW-1:0] r1data_q, r1data_d;
    logic [DW-1:0] r2data_q, r2data_d;
    logic [AW-1:0] rf_r1addr_q, rf_r1addr_d;
    logic [AW-1:0] rf_r2addr_q, rf_r2addr_d;
    logic [AW-1:0] rf_waddr_q, rf_waddr_d;
    logic [DW-1:0] rf_wdata_q, rf_wdata_d;
    logic          rf_reg_write_q, rf_reg_write_d;
    logic          last_q, last_d;

    logic [1:0] elig;
    logic       win_vld;
    logic       win_idx;
    logic       read_cap;

    always_comb begin
        elig    = req & ~gnt_q;
        win_vld = |elig;
        // On a tie the requester that did not win last time goes first.
        win_idx = (elig == 2'b11) ? ~last_q : elig[1];

        gnt_d          = win_vld ? (2'b01 << win_idx) : 2'b00;
        last_d         = win_vld ? win_idx : last_q;
        rf_reg_write_d = win_vld & (win_idx ? we[1] : we[0]);
        rf_r1addr_d    = '0;
        rf_r2addr_d    = '0;
        rf_waddr_d     = '0;
        rf_wdata_d     = '0;
        if (win_vld) begin
            rf_r1addr_d = win_idx ? r1addr[2*AW-1:AW] : r1addr[AW-1:0];
            rf_r2addr_d = win_idx ? r2addr[2*AW-1:AW] : r2addr[AW-1:0];
            rf_waddr_d  = win_idx ? waddr[2*AW-1:AW]  : waddr[AW-1:0];
            rf_wdata_d  = win_idx ? wdata[2*DW-1:DW]  : wdata[DW-1:0];
        end

        read_cap = (|gnt_q) & ~rf_reg_write_q;
        rvalid_d = read_cap ? gnt_q : 2'b00;
        r1data_d = read_cap ? rf_r1data : r1data_q;
        r2data_d = read_cap ? rf_r2data : r2data_q;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q          <= 2'b00;
            rvalid_q       <= 2'b00;
            r1data_q       <= '0;
            r2data_q       <= '0;
            rf_r1addr_q    <= '0;
            rf_r2addr_q    <= '0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            rf_reg_write_q <= 1'b0;
            last_q         <= 1'b1;
        end else begin
            gnt_q          <= gnt_d;
            rvalid_q       <= rvalid_d;
            r1data_q       <= r1data_d;
            r2data_q       <= r2data_d;
            rf_r1addr_q    <= rf_r1addr_d;
            rf_r2addr_q    <= rf_r2addr_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            rf_reg_write_q <= rf_reg_write_d;
            last_q         <= last_d;
        end
    end

    assign gnt          = gnt_q;
    assign rvalid       = rvalid_q;
    assign r1data       = r1data_q;
    assign r2data       = r2data_q;
    assign rf_r1addr    = rf_r1addr_q;
    assign rf_r2addr    = rf_r2addr_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign rf_reg_write = rf_reg_write_q;

endmodule
